// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
//   Run controller for an N-layer MLP inference pipeline. For each layer it
//   issues a one-cycle start pulse to the layer engine and waits for that
//   engine's done. The wait is guarded by a per-layer watchdog, and the run
//   can be cancelled with abort. A timeout is reported through a sticky error
//   flag. The busy cycles of each run are counted.
//
//   Optional feature macro: PER_LAYER_CYCLES_EN
//     When this macro is defined, the block adds a layer_cycles output. It
//     holds one saturating WAIT-cycle count per layer. Without the macro,
//     the port and its counters do not exist.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no run in progress; waiting for run
//   S_START | layer_start[idx] is high this cycle; watchdog is armed
//   S_WAIT  | waiting for layer_done[idx]; the watchdog counts down
//   S_ERROR | the last run timed out; error is held until the next run
//
//   Every output is registered. Each output register is loaded from a value
//   that is decoded from the next state, so busy and layer_start line up with
//   the state they describe.

module mlp_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_WIDTH      = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              run,
  input  logic                              abort,
  input  logic [NUM_LAYERS-1:0]             layer_done,
  output logic [NUM_LAYERS-1:0]             layer_start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [IDX_WIDTH-1:0]              err_layer,
  output logic [CNT_WIDTH-1:0]              total_cycles
`ifdef PER_LAYER_CYCLES_EN
  ,
  output logic [NUM_LAYERS*CNT_WIDTH-1:0]   layer_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // The watchdog is a down-counter. It is loaded in START and reaches its
  // terminal count of zero on WAIT cycle number TIMEOUT_CYCLES.
  localparam int                   WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]      WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LAYERS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                 state, state_nx;
  logic [IDX_WIDTH-1:0]   idx, idx_nx;
  logic [WD_W-1:0]        wdog, wdog_nx;
  logic                   error_nx;
  logic [IDX_WIDTH-1:0]   err_layer_nx;
  logic                   done_nx;
  logic                   busy_nx;
  logic [NUM_LAYERS-1:0]  start_nx;
  logic [CNT_WIDTH-1:0]   total_nx;
  logic                   launch;
  logic                   cur_done;
  logic                   wd_tc;

  // Select the done line of the active layer. Done lines of the other
  // layers never reach the FSM.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx == IDX_WIDTH'(i)) cur_done = layer_done[i];
    end
  end

  assign wd_tc = (wdog == '0);

  // Next-state logic. Priority in START and WAIT is abort, then done, then
  // timeout.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    wdog_nx      = wdog;
    error_nx     = error;
    err_layer_nx = err_layer;
    done_nx      = 1'b0;
    launch       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nx = S_START;
          idx_nx   = '0;
          launch   = 1'b1;
        end
      end
      S_ERROR: begin
        if (run) begin
          state_nx     = S_START;
          idx_nx       = '0;
          error_nx     = 1'b0;
          err_layer_nx = '0;
          launch       = 1'b1;
        end
      end
      S_START: begin
        wdog_nx = WD_LOAD;
        if (abort) state_nx = S_IDLE;
        else       state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (cur_done) begin
          if (idx == LAST_IDX) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_START;
            idx_nx   = idx + IDX_WIDTH'(1);
          end
        end else if (wd_tc) begin
          state_nx     = S_ERROR;
          error_nx     = 1'b1;
          err_layer_nx = idx;
        end else begin
          wdog_nx = wdog - WD_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decode the registered outputs from the next state. The run counter
  // advances on every cycle in which busy is high.
  always_comb begin
    busy_nx  = (state_nx == S_START) || (state_nx == S_WAIT);
    start_nx = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if ((state_nx == S_START) && (idx_nx == IDX_WIDTH'(i))) start_nx[i] = 1'b1;
    end
    total_nx = total_cycles;
    if (launch)                                total_nx = '0;
    else if (busy && (total_cycles != CNT_MAX)) total_nx = total_cycles + CNT_WIDTH'(1);
  end

  // Registers for the state, the layer index, the watchdog and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      wdog         <= '0;
      layer_start  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_layer    <= '0;
      total_cycles <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      wdog         <= wdog_nx;
      layer_start  <= start_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      error        <= error_nx;
      err_layer    <= err_layer_nx;
      total_cycles <= total_nx;
    end
  end

`ifdef PER_LAYER_CYCLES_EN
  // Per-layer WAIT-cycle counters. The cycle that ends a WAIT is included, so
  // a layer that timed out reads TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      layer_cycles <= '0;
    end else if (state == S_WAIT) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if ((idx == IDX_WIDTH'(i)) && (layer_cycles[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX))
          layer_cycles[i*CNT_WIDTH +: CNT_WIDTH] <= layer_cycles[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Testbench for mlp_layer_sequencer (NUM_LAYERS=2, TIMEOUT_CYCLES=100).
// Each run is described by per-layer done delays and an optional abort point.
// The run outcome is computed arithmetically and queued. A monitor compares
// the queued outcome with the DUT whenever a run ends, i.e. when busy falls.

module tb_mlp_layer_sequencer;
  localparam int NL = 2;
  localparam int IW = 4;
  localparam int T  = 100;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          reset, run, abort;
  logic [NL-1:0] layer_done, layer_start;
  logic          busy, done, error;
  logic [IW-1:0] err_layer;
  logic [CW-1:0] total_cycles;
`ifdef PER_LAYER_CYCLES_EN
  logic [NL*CW-1:0] layer_cycles;
`endif

  mlp_layer_sequencer #(
    .NUM_LAYERS(NL), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .layer_done(layer_done), .layer_start(layer_start),
    .busy(busy), .done(done), .error(error), .err_layer(err_layer),
    .total_cycles(total_cycles)
`ifdef PER_LAYER_CYCLES_EN
    , .layer_cycles(layer_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rise_cyc; int fall_cyc;
    bit done; bit err; int el; int total;
    int st0; int st1; int lc0; int lc1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: checks each run's start and end, and the idle behaviour between runs.
  bit            mon_en = 1'b0;
  bit            prev_busy = 1'b0;
  int            st_cnt0, st_cnt1;
  bit            hold_err = 1'b0;
  int            hold_el = 0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (busy && !prev_busy) begin
        if (sb.size() == 0) check("unexpected_run", 1, 0);
        else begin
          check("rise_cycle", cyc, sb[0].rise_cyc);
          check("error_clear_at_start", error, 0);
          check("err_layer_clear_at_start", err_layer, 0);
          check("total_clear_at_start", total_cycles, 0);
        end
        st_cnt0 = 0;
        st_cnt1 = 0;
      end
      if (busy) begin
        check("start_onehot", ($countones(layer_start) <= 1), 1);
        if (layer_start[0]) st_cnt0++;
        if (layer_start[1]) st_cnt1++;
      end else begin
        check("start_while_idle", layer_start, 0);
      end
      if (!busy && prev_busy) begin
        if (sb.size() == 0) check("unexpected_end", 1, 0);
        else begin
          e = sb.pop_front();
          check("fall_cycle", cyc, e.fall_cyc);
          check("done_at_end", done, e.done);
          check("error_at_end", error, e.err);
          check("err_layer_at_end", err_layer, e.el);
          check("total_cycles", total_cycles, e.total);
          check("start_pulses_l0", st_cnt0, e.st0);
          check("start_pulses_l1", st_cnt1, e.st1);
`ifdef PER_LAYER_CYCLES_EN
          check("layer_cycles_l0", layer_cycles[0 +: CW], e.lc0);
          check("layer_cycles_l1", layer_cycles[CW +: CW], e.lc1);
`endif
          hold_err = e.err;
          hold_el  = e.el;
        end
      end else begin
        check("done_outside_end", done, 0);
        if (!busy) begin
          check("error_held", error, hold_err);
          check("err_layer_held", err_layer, hold_el);
        end
      end
      prev_busy = busy;
    end
  end

  // Run one inference. d0/d1 give the WAIT cycle on which each layer raises
  // done; any value above T means the layer never does. ab_l selects the
  // layer that gets the abort (-1 for no abort), and ab_w selects the WAIT
  // cycle of the abort (0 means the START cycle). With noise set, ignored
  // inputs are added at random.
  task automatic run_case(input int d0, input int d1, input int ab_l, input int ab_w, input bit noise);
    int          d[2];
    int          ws[2];
    int          we[2];
    int          lc[2];
    int          st[2];
    int          tot;
    int          s;
    int          cap;
    int          ab_step;
    int          len;
    bit          stop;
    bit          aborted;
    exp_t        e;
    logic [1:0]  dn [0:255];
    logic        ab [0:255];
    logic        rn [0:255];
    d[0] = d0; d[1] = d1;
    tot = 0; stop = 0; aborted = 0; ab_step = -1;
    e.err = 0; e.el = 0;
    for (int i = 0; i < 2; i++) begin
      ws[i] = 1; we[i] = 0; lc[i] = 0; st[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (!stop) begin
        s = tot + 1;
        st[i] = 1;
        tot++;
        cap = (d[i] < T) ? d[i] : T;
        ws[i] = s + 1;
        if (ab_l == i && ab_w <= cap) begin
          tot += ab_w; lc[i] = ab_w; we[i] = s + ab_w;
          ab_step = s + ab_w; aborted = 1; stop = 1;
        end else if (d[i] <= T) begin
          tot += d[i]; lc[i] = d[i]; we[i] = s + d[i];
        end else begin
          tot += T; lc[i] = T; we[i] = s + T;
          e.err = 1; e.el = i; stop = 1;
        end
      end
    end
    e.done  = !stop;
    e.total = tot;
    e.st0 = st[0]; e.st1 = st[1]; e.lc0 = lc[0]; e.lc1 = lc[1];
    len = tot + 5;
    for (int t = 0; t < len; t++) begin
      rn[t] = (t == 0) ? 1'b1 : ((noise && t <= tot) ? ($urandom_range(0, 3) == 0) : 1'b0);
      ab[t] = (aborted && t == ab_step) ? 1'b1 :
              ((noise && (t == 0 || t > tot)) ? ($urandom_range(0, 2) == 0) : 1'b0);
      dn[t] = noise ? 2'($urandom) : 2'b00;
    end
    for (int i = 0; i < 2; i++)
      for (int t = ws[i]; t <= we[i]; t++)
        dn[t][i] = (t == ws[i] - 1 + d[i]);
    e.rise_cyc = cyc + 1;
    e.fall_cyc = cyc + tot + 1;
    sb.push_back(e);
    for (int t = 0; t < len; t++) begin
      run = rn[t]; abort = ab[t]; layer_done = dn[t];
      @(negedge clk);
    end
    run = 1'b0; abort = 1'b0; layer_done = '0;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dr[2];
    int al, aw, cap;
    reset = 1'b1; run = 1'b0; abort = 1'b0; layer_done = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_layer_start", layer_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_layer", err_layer, 0);
    check("rst_total", total_cycles, 0);
`ifdef PER_LAYER_CYCLES_EN
    check("rst_layer_cycles", layer_cycles, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run_case(3, 2, -1, 0, 0);        // basic two-layer run
    run_case(3, 1000, -1, 0, 0);     // layer 1 times out
    run_case(3, 2, -1, 0, 0);        // restart from ERROR
    run_case(10, 2, 0, 5, 0);        // abort on WAIT cycle 5 of layer 0
    run_case(3, 2, -1, 0, 0);
    run_case(3, 2, -1, 0, 1);        // stray done and run while busy
    run_case(T, 2, -1, 0, 0);        // done on the timeout cycle wins
    run_case(4, T, -1, 0, 0);
    run_case(T + 1, 2, -1, 0, 0);    // layer 0 times out
    run_case(6, 3, 0, 6, 0);         // abort and done in the same cycle
    run_case(2, 5, 1, 0, 0);         // abort during START of layer 1
    run_case(1, 1, -1, 0, 1);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 9))
          0:       dr[i] = T;
          1:       dr[i] = T + 1 + $urandom_range(0, 20);
          2:       dr[i] = 1;
          default: dr[i] = $urandom_range(1, 12);
        endcase
      end
      al = -1; aw = 0;
      if ($urandom_range(0, 4) == 0) begin
        al  = $urandom_range(0, 1);
        cap = (dr[al] < T) ? dr[al] : T;
        aw  = $urandom_range(0, cap);
      end
      run_case(dr[0], dr[1], al, aw, $urandom_range(0, 1));
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;

    // A reset in the middle of a run returns every output to its reset value.
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_start", layer_start, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_error", error, 0);
    check("midrun_rst_total", total_cycles, 0);
    reset = 1'b0;
    layer_done = 2'b11;
    @(negedge clk);
    check("midrun_after_done", done, 0);
    check("midrun_after_busy", busy, 0);
    layer_done = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
